bcd_display_sched: RTL
======================

# bcd_display_sched

Shared binary-to-decimal conversion and display scheduler for the calculator. Two requesters, the operand-entry path and the ALU result path, compete for one sequential double-dabble converter through a round-robin request/grant handshake. The block turns a 24-bit two's-complement value into six BCD digits plus sign and overflow flags. It also continuously scans the latched digits onto a six-digit multiplexed 7-segment display.

## Interface
- SCAN_DIV, 50000, clock cycles each digit stays enabled (≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-requester conversion request; requester holds until its gnt
- val0  in  24  requester 0 value, two's complement, valid while req[0]
- val1  in  24  requester 1 value, two's complement, valid while req[1]
- gnt  out  2  one-cycle grant pulse, one-hot
- busy  out  1  conversion in progress (LOAD..DONE)
- done  out  1  one-cycle pulse; bcd/neg/ovf updated this cycle
- bcd  out  24  six BCD digits, [3:0] = units
- neg  out  1  converted value was negative
- ovf  out  1  magnitude > 999999
- an  out  6  digit enables, active-low, one-hot-zero
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1

## Operation
- FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE: if any req, pick winner, latch its val, pulse gnt, go LOAD. Round-robin pointer starts at 0 after reset. Both requesting: the pointer side wins, and the pointer then moves to the other side. Single request: it wins and the pointer moves to the other side.
- req while busy: not granted, no effect; stays pending.
- LOAD: neg = val[23]; magnitude = neg ? (2^24 − val) mod 2^24 : val, 24-bit. 0x800000 yields magnitude 8388608. Clear the 28-bit (7-digit) BCD shift register.
- SHIFT: 24 cycles. Each cycle, add 3 to every digit ≥5, then shift left one, taking the magnitude MSB. A 5-bit counter terminates the state.
- DONE: bcd ← low 6 digits, ovf ← (digit 6 ≠ 0), neg ← latched sign, done = 1.
- Display: free-running divider counts to SCAN_DIV−1. On wrap, digit index advances 0→5→0; an[i] = 0 for the current index i.
- seg per digit, by priority:
  - ovf: digit 0 shows 'E' (8'h86), others blank (8'hFF).
  - neg: digit 5 shows '-' (8'hBF). Digit 5's value stays visible on bcd only.
  - else: hex-to-7seg of the BCD digit (0 = 8'hC0).
- Display always reflects the last completed conversion. It updates the cycle after done.

## Timing
- Reset values: gnt 0, busy 0, done 0, bcd 0, neg 0, ovf 0, an 6'b111110, seg 8'hC0, FSM IDLE, pointer 0, scan counter and index 0.
- req seen at edge E: gnt high cycle E+1 (LOAD), val sampled at E.
- SHIFT occupies cycles E+2..E+25; done and new bcd in cycle E+26; IDLE again E+27.
- Back-to-back: the earliest next gnt is E+28. busy is high E+1..E+26.
- rst mid-conversion: immediately abort to reset values. The granted request is lost, and the requester must re-request.
- seg/an are registered, one cycle behind the index change.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero digit show blank (8'hFF). Digit 0 is never blanked. '-' and 'E' rules are unchanged.
- Undefined: all six digits always shown, leading zeros as 8'hC0.

## Structure
- calc_pkg: FSM state enum, NDIG = 6, DATA_W = 24, segment constants (SEG_BLANK, SEG_MINUS, SEG_E, digit table).
- One sub-module, bcd_seg_decode: combinational 4-bit digit + blank/minus/E selects → seg. The FSM, arbiter, shifter and scanner stay in the top.

## Test plan
- req[0], val0 = 24'd123456 → gnt = 2'b01 one cycle; done 25 cycles after gnt; bcd = 24'h123456, neg 0, ovf 0.
- req[1], val1 = 24'hFFFFFF → bcd = 24'h000001, neg 1, ovf 0; digit 5 seg = 8'hBF.
- val0 = 24'h800000 → neg 1, ovf 1, bcd = 24'h388608; digit 0 = 8'h86, others 8'hFF.
- Both req held from reset → gnt 01, then 10 at the next IDLE. Re-raise both → gnt 01. req[1] during busy → no gnt until IDLE.
- rst pulsed at 10th SHIFT cycle → all outputs at reset values asynchronously. New request for 24'd42 then gives bcd = 24'h000042.
- SCAN_DIV = 4, bcd = 24'h000042 → an steps 111110, 111101, … every 4 cycles. Digits 2–5 show 8'hFF with LEADING_ZERO_BLANK_EN and 8'hC0 without.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator display path.
//   state_t   - converter FSM states
//   NDIG      - number of displayed decimal digits
//   DATA_W    - width of the two's-complement input value
//   BCD_W     - width of the double-dabble shift register (one spare digit)
//   SEG_*     - active-low 7-segment patterns {dp,g,f,e,d,c,b,a}
//   digit_seg - hex digit to active-low segment pattern
package calc_pkg;

    localparam int NDIG   = 6;
    localparam int DATA_W = 24;
    localparam int BCD_W  = 4 * (NDIG + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;

    function automatic logic [7:0] digit_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: combinational segment selector for one display digit.
//   digit - BCD digit value
//   blank - show nothing
//   minus - show '-'
//   err   - show 'E'
//   seg   - active-low segments {dp,g,f,e,d,c,b,a}, dp always off
// Priority: err > minus > blank > digit. Minus beats blank so that leading
// zero blanking can never hide the sign.
module bcd_seg_decode
    import calc_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    input  logic       err,
    output logic [7:0] seg
);

    always_comb begin
        seg = digit_seg(digit);
        if (err) begin
            seg = SEG_E;
        end else if (minus) begin
            seg = SEG_MINUS;
        end else if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/bcd_display_sched.sv
// bcd_display_sched: round-robin shared binary-to-BCD converter plus a
// six-digit multiplexed 7-segment scanner.
//   clk, rst    - clock, asynchronous active-high reset
//   req[1:0]    - conversion requests; a requester holds req until its gnt
//   val0, val1  - 24-bit two's-complement values, valid while matching req
//   gnt[1:0]    - one-cycle one-hot grant; the value is latched at that edge
//   busy        - conversion in progress (LOAD..DONE)
//   done        - one-cycle pulse when bcd/neg/ovf take new values
//   bcd, neg, ovf - last conversion: six BCD digits, sign, magnitude > 999999
//   an, seg     - active-low digit enables and segments, registered
// Handshake: a request is only arbitrated while the FSM is IDLE; the winner
// sees gnt for exactly one cycle and may drop req from then on, the loser
// (and any request raised while busy) simply stays pending.
// Build option: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit (digit 0 is never blanked).
module bcd_display_sched
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] val0,
    input  logic [DATA_W-1:0] val1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] bcd,
    output logic              neg,
    output logic              ovf,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        seg
);

    localparam logic [4:0] SHIFT_LAST = 5'(DATA_W - 1);
    localparam int         DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t            state;
    logic              ptr;
    logic              win;
    logic [DATA_W-1:0] val_q;
    logic [DATA_W-1:0] mag;
    logic              sign_q;
    logic [BCD_W-1:0]  sr;
    logic [BCD_W-1:0]  sr_adj;
    logic [BCD_W-1:0]  sr_next;
    logic [4:0]        cnt;

    // Both requesting: pointer side wins. Otherwise the lone requester wins.
    assign win = (req == 2'b11) ? ptr : req[1];

    // One double-dabble step: +3 on every digit >= 5, then shift in mag MSB.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < NDIG + 1; i++) begin
            if (sr[4*i +: 4] >= 4'd5) begin
                sr_adj[4*i +: 4] = sr[4*i +: 4] + 4'd3;
            end
        end
        sr_next = {sr_adj[BCD_W-2:0], mag[DATA_W-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= 1'b0;
            gnt    <= 2'b00;
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            val_q  <= '0;
            mag    <= '0;
            sign_q <= 1'b0;
            sr     <= '0;
            cnt    <= '0;
        end else begin
            gnt  <= 2'b00;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt   <= win ? 2'b10 : 2'b01;
                        val_q <= win ? val1 : val0;
                        ptr   <= ~win;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Negation of 0x800000 wraps to itself, i.e. 8388608.
                    sign_q <= val_q[DATA_W-1];
                    mag    <= val_q[DATA_W-1] ? -val_q : val_q;
                    sr     <= '0;
                    cnt    <= '0;
                    state  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr  <= sr_next;
                    mag <= {mag[DATA_W-2:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == SHIFT_LAST) begin
                        // Results are published from the final step so that
                        // they are visible together with done in DONE.
                        bcd   <= sr_next[DATA_W-1:0];
                        ovf   <= |sr_next[BCD_W-1:DATA_W];
                        neg   <= sign_q;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Display scanner.
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [3:0]       cur_digit;
    logic             sel_blank;
    logic             sel_minus;
    logic             sel_err;
    logic             lead_zero;
    logic [7:0]       seg_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 3'd0;
        end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= (idx == 3'(NDIG - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        cur_digit = bcd[{idx, 2'b00} +: 4];
        lead_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and every digit above it are zero.
        lead_zero = (idx != 3'd0) && ((bcd >> {idx, 2'b00}) == '0);
`endif
        sel_err   = ovf && (idx == 3'd0);
        sel_minus = !ovf && neg && (idx == 3'(NDIG - 1));
        sel_blank = (ovf && (idx != 3'd0)) || lead_zero;
    end

    bcd_seg_decode u_dec (
        .digit (cur_digit),
        .blank (sel_blank),
        .minus (sel_minus),
        .err   (sel_err),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 6'b111110;
            seg <= 8'hC0;
        end else begin
            an  <= ~(6'b000001 << idx);
            seg <= seg_next;
        end
    end

endmodule
